// File: rtl/bias_seq_if.sv
// Signal bundle between the bias sequencer and its controller / bias_add datapath.
// The master side (controller) drives config, start and the upstream valid;
// the slave side (bias_seq) returns the bias word and the regenerated stream flags.
interface bias_seq_if #(
    parameter int NUM_WIDTH = 16,
    parameter int CH_WIDTH  = 8,
    parameter int PX_WIDTH  = 16
) ();
    logic                 cfg_wr;
    logic [CH_WIDTH-1:0]  cfg_addr;
    logic [NUM_WIDTH-1:0] cfg_data;
    logic                 cfg_ready;
    logic                 start;
    logic [CH_WIDTH-1:0]  num_ch;
    logic [PX_WIDTH-1:0]  num_px;
    logic                 up_valid;
    logic [NUM_WIDTH-1:0] bias;
    logic                 dn_valid;
    logic                 dn_last;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output cfg_wr, cfg_addr, cfg_data, start, num_ch, num_px, up_valid,
        input  cfg_ready, bias, dn_valid, dn_last, busy, done, err
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_data, start, num_ch, num_px, up_valid,
        output cfg_ready, bias, dn_valid, dn_last, busy, done, err
    );
endinterface

// File: rtl/bias_seq.sv
// Bias sequencer: holds the per-channel bias table and steps the bias word presented
// to bias_add in lockstep with accepted beats, regenerating valid/last across
// bias_add's one-cycle register and flagging the end of a layer pass.
module bias_seq #(
    parameter int NUM_WIDTH = 16,
    parameter int CH_WIDTH  = 8,
    parameter int PX_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    bias_seq_if.slave  bus
);
    localparam int                  DEPTH   = 1 << CH_WIDTH;
    localparam logic [CH_WIDTH-1:0] CH_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    // Bias table: deliberately not reset so contents survive rst_n.
    logic [NUM_WIDTH-1:0] r_mem [DEPTH];

    logic [CH_WIDTH-1:0]  r_num_ch;
    logic [PX_WIDTH-1:0]  r_num_px;
    logic [CH_WIDTH-1:0]  r_ch_idx;
    logic [PX_WIDTH-1:0]  r_px_cnt;
    logic [NUM_WIDTH-1:0] r_bias;
    logic                 r_dn_valid;
    logic                 r_dn_last;
    logic                 r_done;
    logic                 r_err;

    logic                 w_in_idle;
    logic                 w_in_run;
    logic                 w_start_go;
    logic                 w_wr_en;
    logic                 w_beat;
    logic                 w_ch_end;
    logic                 w_final;
    logic [CH_WIDTH-1:0]  w_ch_nxt;
    logic                 w_fwd0;

    assign w_in_idle  = (r_state == S_IDLE);
    assign w_in_run   = (r_state == S_RUN);
    assign w_start_go = w_in_idle & bus.start;
    assign w_wr_en    = w_in_idle & bus.cfg_wr;
    assign w_beat     = w_in_run & bus.up_valid;
    assign w_ch_end   = (r_px_cnt == r_num_px);
    assign w_final    = w_beat & w_ch_end & (r_ch_idx == r_num_ch);
    assign w_ch_nxt   = r_ch_idx + 1'b1;
    // A write to entry 0 in the start cycle must reach the bias register directly.
    assign w_fwd0     = w_wr_en & (bus.cfg_addr == CH_ZERO);

    assign bus.bias     = r_bias;
    assign bus.dn_valid = r_dn_valid;
    assign bus.dn_last  = r_dn_last;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded status outputs.
    always_comb begin
        w_state_nxt   = r_state;
        bus.busy      = 1'b1;
        bus.cfg_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.busy      = 1'b0;
                bus.cfg_ready = 1'b1;
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_final) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Table writes, accepted only while idle.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Pass limits, pixel/channel counters and the bias word; bias advances only on
    // the edge that consumes the last pixel of a channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_ch <= '0;
            r_num_px <= '0;
            r_ch_idx <= '0;
            r_px_cnt <= '0;
            r_bias   <= '0;
        end else if (w_start_go) begin
            r_num_ch <= bus.num_ch;
            r_num_px <= bus.num_px;
            r_ch_idx <= '0;
            r_px_cnt <= '0;
            r_bias   <= w_fwd0 ? bus.cfg_data : r_mem[CH_ZERO];
        end else if (w_beat) begin
            if (w_ch_end) begin
                r_px_cnt <= '0;
                if (r_ch_idx != r_num_ch) begin
                    r_ch_idx <= w_ch_nxt;
                    r_bias   <= r_mem[w_ch_nxt];
                end
            end else begin
                r_px_cnt <= r_px_cnt + 1'b1;
            end
        end
    end

    // Stream flags delayed one cycle to match bias_add, plus the sticky misuse flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dn_valid <= 1'b0;
            r_dn_last  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_dn_valid <= w_beat;
            r_dn_last  <= w_final;
            r_done     <= w_final;
            if (bus.up_valid && !w_in_run) begin
                r_err <= 1'b1;
            end else if (w_start_go) begin
                r_err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/bias_seq.md
# bias_seq

Sequencer for the bias stage of the convolution output path. It holds a per-output-channel bias table written over a config port, and presents the correct bias to `bias_add` in step with each valid beat of the accumulated stream. It tracks pixel and channel counts, regenerates the stream valid and last flags across `bias_add`'s one-cycle latency, and reports completion of a layer pass.

## Interface
- NUM_WIDTH, 16, bias and data word width (matches `bias_add`)
- CH_WIDTH, 8, channel index width; table depth is 2^CH_WIDTH
- PX_WIDTH, 16, pixels-per-channel counter width

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  bias table write strobe
- cfg_addr  in  CH_WIDTH  table write address
- cfg_data  in  NUM_WIDTH  bias value to write
- cfg_ready  out  1  high when table writes and start are accepted (IDLE only)
- start  in  1  begin a pass; sampled in IDLE only
- num_ch  in  CH_WIDTH  channels minus one, latched at start
- num_px  in  PX_WIDTH  pixels per channel minus one, latched at start
- up_valid  in  1  beat of `up_data` presented to `bias_add` this cycle
- bias  out  NUM_WIDTH  registered bias, driven to `bias_add.bias`
- dn_valid  out  1  `bias_add.dn_data` valid this cycle
- dn_last  out  1  final beat of the pass on `dn_data`
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse coincident with dn_last
- err  out  1  sticky flag: up_valid seen outside RUN; cleared at start

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: cfg_ready=1.
  - A cfg_wr writes mem[cfg_addr] <= cfg_data.
  - On start: latch num_ch and num_px, clear ch_idx and px_cnt, clear err, load bias <= mem[0], go to RUN.
  - If cfg_wr to address 0 and start occur in the same cycle, bias loads cfg_data (write forwarding).
- RUN: cfg_ready=0, and cfg_wr is ignored. On each up_valid:
  - If px_cnt==num_px_q, clear px_cnt. If ch_idx==num_ch_q, this is the final beat: go to FLUSH. Otherwise ch_idx+1 and bias <= mem[ch_idx+1].
  - Otherwise px_cnt+1.
  - With up_valid low, all counters and bias hold. Gaps are allowed with no limit.
- FLUSH: lasts one cycle, then returns to IDLE. Start is ignored in FLUSH. up_valid in FLUSH sets err.
- Bias update rule: bias changes only on the edge that consumes the last pixel of a channel. `bias_add` therefore samples the old bias with that last beat.
- up_valid in IDLE or FLUSH: no dn_valid is produced and err is set.
- There is no backpressure; the downstream consumer must accept every dn_valid beat.
- Table memory has no reset. Its contents survive rst_n and are undefined after power-up.
- Counters do not wrap in RUN beyond the limits latched at start.

## Timing
- Reset values:
  - state=IDLE
  - bias=0, dn_valid=0, dn_last=0, done=0, err=0
  - busy=0, cfg_ready=1
  - counters=0
- Start to first accepted beat: bias is valid the cycle after start, so up_valid may assert on the cycle after start.
- dn_valid(t+1) = up_valid(t) while in RUN. This matches the single register in `bias_add`.
- dn_last and done assert in the cycle after the final beat, which is the FLUSH cycle. busy drops the following cycle.
- Table write to readable: one cycle, apart from the address-0 forwarding case in the start cycle.
- Reset asserted mid-pass:
  - Return to IDLE immediately.
  - dn_valid, dn_last and done clear asynchronously.
  - The in-flight beat is lost.
  - No done is generated.
- Total pass: (num_ch+1)*(num_px+1) up_valid beats. Pass length is unaffected by gaps.

## Test plan
- Load mem[0..3]={10,-5,0x7FFF,1}, num_ch=3, num_px=2, up_valid continuous for 12 beats -> bias sequence 10×3, -5×3, 0x7FFF×3, 1×3 aligned to beats; dn_valid high 12 cycles lagging by 1; dn_last/done only on the 12th output.
- Same config with up_valid toggling 1,0,0,1... -> bias changes only after every 3rd accepted beat; dn_valid mirrors up_valid delayed 1; total output beats=12.
- num_ch=0, num_px=0, one beat -> FLUSH next cycle with dn_valid=dn_last=done=1; busy low two cycles after the beat.
- start with cfg_wr addr 0 data 0x1234 in the same cycle -> bias=0x1234 the next cycle; cfg_wr issued during RUN leaves the table unchanged (verified on a following pass).
- up_valid pulsed in IDLE -> err=1, dn_valid stays 0; next start clears err.
- rst_n low during the 5th beat of a 12-beat pass -> outputs reset immediately, no done; a new start afterwards runs a full clean pass using the preserved table.
